// File: rtl/fsqrt_arb_pkg.sv
// fsqrt_arb_pkg: shared FPU types and constants for the fsqrt arbiter.
package fsqrt_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EVAL, S_RESP} state_t;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  // Zero, infinity and negative operands bypass the datapath result.
  function automatic logic [31:0] fp_final(input logic [31:0] op, input logic [31:0] sq);
    return (op[30:23] == 8'd0) ? {op[31], 31'b0} :
           op[31]              ? QNAN :
           (&op[30:23])        ? op : sq;
  endfunction
endpackage

// File: rtl/fsqrt_arb_fsqrt.sv
// fsqrt_arb_fsqrt: single-precision square root of positive normals, one output register.
module fsqrt_arb_fsqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_op,
  output logic [31:0] o_res
);
  logic [47:0] w_rad;
  logic [26:0] w_rem, w_trial;
  logic [23:0] w_root;
  logic        w_ge;
  logic [7:0]  w_exp;
  logic [31:0] r_res;
  // Odd biased exponent means even unbiased exponent, so the radicand needs one less shift.
  assign w_exp = 8'((9'(i_op[30:23]) + 9'd126 + 9'(i_op[23])) >> 1);
  always_comb begin
    w_rad = i_op[23] ? {2'b01, i_op[22:0], 23'b0} : {1'b1, i_op[22:0], 24'b0};
    w_rem = '0;
    w_root = '0;
    w_trial = '0;
    w_ge = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      w_rem = {w_rem[24:0], w_rad[2*i +: 2]};
      w_trial = {1'b0, w_root, 2'b01};
      w_ge = w_rem >= w_trial;
      w_rem = w_ge ? w_rem - w_trial : w_rem;
      w_root = {w_root[22:0], w_ge};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_res <= '0;
    else     r_res <= w_root[23] ? {i_op[31], w_exp, w_root[22:0]} : '0;
  assign o_res = r_res;
endmodule

// File: rtl/fsqrt_arb.sv
// fsqrt_arb: round-robin sharing of one fsqrt unit between two requesters.
module fsqrt_arb
  import fsqrt_arb_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_src,
  output logic             busy
);
  state_t           r_state, w_next;
  logic             r_prio, r_src;
  logic [31:0]      r_op, r_res, w_sq;
  logic [TAG_W-1:0] r_tag;
  logic             w_idle, w_any, w_gnt1;
  assign w_idle = r_state == S_IDLE;
  assign w_any  = req0_valid | req1_valid;
  assign w_gnt1 = req1_valid & (~req0_valid | r_prio);
  always_comb begin
    w_next = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_next = (r_state == S_IDLE) ? (w_any ? S_CALC : S_IDLE) :
             (r_state == S_CALC) ? S_EVAL :
             (r_state == S_EVAL) ? S_RESP :
             (resp_ready ? S_IDLE : S_RESP);
    req0_ready = w_idle & req0_valid & ~w_gnt1;
    req1_ready = w_idle & w_gnt1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_op    <= '0;
      r_tag   <= '0;
      r_src   <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle & w_any) begin
        r_op   <= w_gnt1 ? req1_data : req0_data;
        r_tag  <= w_gnt1 ? req1_tag : req0_tag;
        r_src  <= w_gnt1;
        r_prio <= ~w_gnt1;
      end
      if (r_state == S_EVAL) r_res <= fp_final(r_op, w_sq);
    end
  fsqrt_arb_fsqrt u_fsqrt (
    .clk  (clk),
    .rst  (rst),
    .i_op (r_op),
    .o_res(w_sq)
  );
  assign resp_valid = r_state == S_RESP;
  assign busy       = ~w_idle;
  assign resp_data  = r_res;
  assign resp_tag   = r_tag;
  assign resp_src   = r_src;
endmodule

// File: tb/tb_fsqrt_arb.sv
// tb_fsqrt_arb: directed and random checks of fsqrt_arb against a real-arithmetic reference.
module tb_fsqrt_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data, resp_data;
  logic [4:0]  req0_tag, req1_tag, resp_tag;
  logic        resp_valid, resp_ready, resp_src, busy;
  int          checks = 0;
  int          errors = 0;
  bit          next_pref = 1'b0;
  always #5 clk = ~clk;
  fsqrt_arb #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_src(resp_src), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask
  // Square root via double precision, truncated to single; exact enough to equal a floor.
  function automatic logic [31:0] ref_final(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return {x[31], 31'b0};
    if (x[31]) return 32'h7FC00000;
    if (x[30:23] == 8'hFF) return x;
    d = {1'b0, 11'(x[30:23] + 896), x[22:0], 29'b0};
    d = $realtobits($sqrt($bitstoreal(d)));
    return {1'b0, 8'(d[62:52] - 896), d[51:29]};
  endfunction
  function automatic logic [31:0] rand_op();
    int k = $urandom_range(0, 7);
    logic [31:0] m = $urandom;
    case (k)
      0:       return {m[31], 8'h00, m[22:0]};
      1:       return {m[31], 8'hFF, m[22:0]};
      2:       return {1'b1, 8'($urandom_range(1, 254)), m[22:0]};
      default: return {1'b0, 8'($urandom_range(1, 254)), m[22:0]};
    endcase
  endfunction
  task automatic op_cycle(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [4:0] t0, input logic [4:0] t1, input int stall);
    logic [31:0] ed;
    logic [4:0]  et;
    bit          w;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    req0_tag = t0; req1_tag = t1; resp_ready = (stall == 0);
    #1;
    w = (v0 && v1) ? next_pref : v1;
    chk("req0_ready_grant", 32'(req0_ready), 32'(v0 && !w));
    chk("req1_ready_grant", 32'(req1_ready), 32'(w));
    ed = ref_final(w ? d1 : d0);
    et = w ? t1 : t0;
    next_pref = !w;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req0_data = $urandom; req1_data = $urandom; req0_tag = 5'($urandom); req1_tag = 5'($urandom);
      #1;
      chk("resp_valid_latency", 32'(resp_valid), 32'(c == 3));
      chk("busy_active", 32'(busy), 32'd1);
      chk("req0_ready_blocked", 32'(req0_ready), 32'd0);
      chk("req1_ready_blocked", 32'(req1_ready), 32'd0);
    end
    chk("resp_data", resp_data, ed);
    chk("resp_tag", 32'(resp_tag), 32'(et));
    chk("resp_src", 32'(resp_src), 32'(w));
    repeat (stall) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, ed);
      chk("stall_tag", 32'(resp_tag), 32'(et));
      chk("stall_src", 32'(resp_src), 32'(w));
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("handshake_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    req0_tag = '0; req1_tag = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_resp_src", 32'(resp_src), 32'd0);
    rst = 1'b0;
    next_pref = 1'b0;
    // Both requesters held valid: req0 first, then strict alternation.
    op_cycle(1, 1, 32'h40800000, 32'h41100000, 5'd1, 5'd2, 0);
    chk("first_src_is_0", 32'(resp_src), 32'd0);
    op_cycle(1, 1, 32'h41800000, 32'h40800000, 5'd4, 5'd5, 0);
    chk("second_src_is_1", 32'(resp_src), 32'd1);
    chk("second_data", resp_data, 32'h40000000);
    repeat (4) op_cycle(1, 1, rand_op(), rand_op(), 5'($urandom), 5'($urandom), 0);
    op_cycle(1, 0, 32'h40800000, 32'h3F800000, 5'd3, 5'd7, 0);
    chk("four_data", resp_data, 32'h40000000);
    chk("four_tag", 32'(resp_tag), 32'd3);
    chk("four_src", 32'(resp_src), 32'd0);
    op_cycle(0, 1, 32'h0, 32'h00000000, 5'd0, 5'd9, 0);
    chk("zero", resp_data, 32'h00000000);
    op_cycle(1, 0, 32'h80000000, 32'h0, 5'd10, 5'd0, 0);
    chk("neg_zero", resp_data, 32'h80000000);
    op_cycle(0, 1, 32'h0, 32'h7F800000, 5'd0, 5'd11, 0);
    chk("pos_inf", resp_data, 32'h7F800000);
    op_cycle(1, 0, 32'hC0800000, 32'h0, 5'd12, 5'd0, 0);
    chk("neg_nan", resp_data, 32'h7FC00000);
    op_cycle(1, 1, rand_op(), rand_op(), 5'd13, 5'd14, 5);
    // Reset while the operand is in EVAL must drop it silently.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h41C80000; req0_tag = 5'd21;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("eval_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_data", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_pref = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
    end
    op_cycle(1, 1, 32'h41C80000, 32'h40800000, 5'd22, 5'd23, 0);
    chk("post_rst_data", resp_data, 32'h40A00000);
    chk("post_rst_src", 32'(resp_src), 32'd0);
    for (int i = 0; i < 40; i++) begin
      int v = $urandom_range(1, 3);
      int s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      op_cycle(v[0], v[1], rand_op(), rand_op(), 5'($urandom), 5'($urandom), s);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsqrt_arb.md
FSQRT_ARB -- requirements
Module: fsqrt_arb

Interface
REQ-001 Parameter TAG_W, default 5, width of the requester tag (destination register id).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand.
REQ-005 req0_ready  output  1  requester 0 operand accepted this cycle when valid is also high.
REQ-006 req0_data  input  32  requester 0 IEEE-754 single operand.
REQ-007 req0_tag  input  TAG_W  requester 0 tag.
REQ-008 req1_valid / req1_ready / req1_data / req1_tag  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_data  output  32  square-root result.
REQ-012 resp_tag  output  TAG_W  tag of the accepted operand.
REQ-013 resp_src  output  1  index of the requester that issued the operand.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL share one fsqrt instance (1-register, two-stage) between two requesters; one operation in flight at most.
REQ-016 FSM states SHALL be IDLE, CALC, EVAL, RESP.
REQ-017 IDLE: if any reqN_valid, grant one; reqN_ready = (state==IDLE) & grant_N (combinational); latch data/tag/src into op register; next CALC.
REQ-018 Arbitration SHALL be round-robin: a prio bit selects the winner when both are valid; after each grant prio points to the other requester; a single valid requester always wins.
REQ-019 CALC: the fsqrt input SHALL be the op register; next EVAL unconditionally.
REQ-020 EVAL: the fsqrt result SHALL be valid; the result register loads the final value (REQ-022); next RESP.
REQ-021 RESP: resp_valid=1; resp_data/tag/src SHALL be held stable until resp_valid & resp_ready; then next IDLE.
REQ-022 Special operands SHALL override the fsqrt output in EVAL: exponent==0 -> {sign,31'b0}; exponent==255 and sign==0 -> operand unchanged; sign==1 and exponent!=0 -> 32'h7FC00000.
REQ-023 Latency SHALL be 3 cycles from the accept edge to resp_valid high; max throughput is 1 operation per 4 cycles.
REQ-024 The fsqrt input operand SHALL remain unchanged from CALC through EVAL.
REQ-025 A requester not granted SHALL see ready=0; its valid/data SHALL be ignored (not latched).
REQ-026 No request SHALL be accepted in CALC, EVAL or RESP, including the RESP cycle in which the response handshake completes.

Reset
REQ-027 On rst the block SHALL asynchronously enter IDLE with prio=0 and op/result registers cleared.
REQ-028 During and after reset: resp_valid=0, busy=0, resp_data=0, resp_tag=0, resp_src=0.
REQ-029 Reset mid-operation SHALL discard the in-flight operation with no response.

Structure
REQ-030 State encoding and the canonical NaN constant 32'h7FC00000 SHALL reside in the shared FPU package.
REQ-031 The existing fsqrt module SHALL be the only sub-module.

Verification
REQ-032 req0 data 32'h40800000 (4.0), tag 3 -> resp_valid 3 cycles later; resp_data 32'h40000000; resp_tag 3; resp_src 0.
REQ-033 req0 and req1 valid together after reset -> req0 granted first, then req1; second response resp_src 1; with both held valid, grants strictly alternate.
REQ-034 Operands 32'h00000000, 32'h80000000, 32'h7F800000, 32'hC0800000 -> 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000.
REQ-035 resp_ready held 0 for 5 cycles in RESP -> outputs stable; both req_ready stay 0; one response on release.
REQ-036 rst asserted in EVAL -> resp_valid never rises for that operand; next request completes normally.
